pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset sequencer sitting directly downstream of the system PLL on the 50 MHz reference clock. It drives the PLL's `rst` and consumes its asynchronous `locked` flag. It releases a synchronous system reset only after lock has been continuously stable and a hold-off has elapsed. On loss of lock it re-asserts system reset and restarts the PLL. Optionally it retries the PLL when lock is never achieved.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required.
- `RST_HOLD_CYCLES`, 64: cycles `sys_rst` is held after lock is qualified.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles in WAIT_LOCK before a retry (macro-dependent).
- `CNT_W`, 17: counter width; must hold max(all cycle parameters).

Ports:
- `refclk`  in  1  50 MHz clock, the block's only clock.
- `rst`  in  1  Reset: asynchronous, active-high.
- `pll_locked`  in  1  PLL lock flag; asynchronous to `refclk`.
- `clr_status`  in  1  Synchronous pulse; clears `lock_lost` and `retry_cnt`.
- `pll_rst`  out  1  Reset to the PLL, active-high, registered.
- `sys_rst`  out  1  System reset, active-high, registered, synchronous to `refclk`.
- `ready`  out  1  High only in RUN.
- `lock_lost`  out  1  Sticky; set when lock drops while in RUN.
- `retry_cnt`  out  4  Saturating count of timeout retries (0–15).

## Operation
- `pll_locked` passes through a 2-flop synchronizer. The result `locked_s` drives all decisions.
- FSM states:
  - **S_PLL_RST:** `pll_rst`=1, `sys_rst`=1. Count cycles; after `PLL_RST_CYCLES` → S_WAIT_LOCK with counters cleared.
  - **S_WAIT_LOCK:** `pll_rst`=0, `sys_rst`=1. The stable counter increments while `locked_s`=1 and clears to 0 on any `locked_s`=0. After `LOCK_STABLE_CYCLES` consecutive highs → S_HOLD.
  - **S_HOLD:** `sys_rst`=1. Count `RST_HOLD_CYCLES` → S_RUN. If `locked_s`=0 at any point, go → S_WAIT_LOCK; `lock_lost` is not set.
  - **S_RUN:** `sys_rst`=0, `ready`=1. If `locked_s`=0 → S_PLL_RST and set `lock_lost`.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- `clr_status` clears both status outputs. If a set/increment event occurs in the same cycle, the set/increment wins.
- `retry_cnt` saturates at 15.
- Counters never wrap: each counter is reset on every state entry.

## Timing
- Values during and after `rst`:
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `lock_lost`=0, `retry_cnt`=0.
  - State = S_PLL_RST; synchronizer flops = 0.
- After `rst` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges.
- Lock-to-release latency: let `pll_locked` rise and stay high, first sampled at edge k. `sys_rst` falls and `ready` rises at edge k+2+`LOCK_STABLE_CYCLES`+`RST_HOLD_CYCLES`.
- Lock-loss latency: `pll_locked` falls, sampled at edge k. At edge k+2, `sys_rst`=1, `ready`=0, `lock_lost`=1 and `pll_rst`=1.
- A glitch on `pll_locked` shorter than one cycle may be missed. A glitch of one cycle or longer is always seen.
- `rst` asserted mid-operation forces reset values asynchronously, regardless of state.

## Configuration
- Macro: `PLL_LOCK_TIMEOUT_EN`.
- **Defined:** a timeout counter runs in S_WAIT_LOCK; it is not cleared by `locked_s` toggles. On reaching `LOCK_TIMEOUT_CYCLES` → S_PLL_RST and `retry_cnt`+1 (saturating).
- **Undefined:** S_WAIT_LOCK waits indefinitely. `retry_cnt` is tied to 0 and the timeout counter is not built. `LOCK_TIMEOUT_CYCLES` is ignored.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32.
- **Reset values:** hold `rst` high 3 cycles, then release with `pll_locked`=0 → all outputs at reset values during `rst`; `pll_rst` high for exactly 4 edges after release, then 0.
- **Clean lock:** `pll_locked` rises at edge 10 and stays high → `sys_rst` falls and `ready` rises at edge 24; `lock_lost`=0.
- **Lock chatter:** `pll_locked` high 5 cycles, low 1, then high → stable count restarts; release at 2+8+4 edges after the final rise.
- **Lock loss in RUN:** from RUN, drop `pll_locked` at edge k → at edge k+2, `sys_rst`=1, `ready`=0, `lock_lost`=1, `pll_rst`=1 for 4 cycles. Then pulse `clr_status` → `lock_lost`=0.
- **Timeout (macro defined):** hold `pll_locked`=0 → `pll_rst` re-pulses every 4+32 cycles and `retry_cnt` counts 1, 2, … up to 15, then stays at 15.
- **Timeout (macro undefined):** same stimulus → `pll_rst` is never re-pulsed and `retry_cnt`=0 throughout.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : Holds the PLL and the system in reset until lock is qualified.
//           Optional lock-timeout retry is built when PLL_LOCK_TIMEOUT_EN
//           is defined.
// Revision: 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clr_status,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam logic [CNT_W-1:0] c_pll_rst_last = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_done  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    logic             r_sync_meta;
    logic             r_locked_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lost_evt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_lock_lost;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_tmo;
    logic             w_timeout;
    logic [3:0]       r_retry_cnt;
`endif

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_locked_s  <= r_sync_meta;
        end
    end

    // The shared counter restarts at every state entry so it can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_lost_evt  = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == c_pll_rst_last) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (!r_locked_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_stable_done) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                // Lock qualification takes priority over a coincident timeout.
                if (w_state_nxt == S_WAIT_LOCK && r_tmo == c_tmo_last) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_cnt_nxt = '0;
                if (!r_locked_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_lost_evt  = 1'b1;
                end
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as r_state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pll_rst <= (w_state_nxt == S_PLL_RST);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            if (w_lost_evt) begin
                r_lock_lost <= 1'b1;
            end else if (clr_status) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_tmo       <= '0;
            r_retry_cnt <= 4'd0;
        end else begin
            if (r_state != S_WAIT_LOCK || w_state_nxt != S_WAIT_LOCK) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_cnt_one;
            end
            if (w_timeout) begin
                if (r_retry_cnt != 4'hF) begin
                    r_retry_cnt <= r_retry_cnt + 4'd1;
                end
            end else if (clr_status) begin
                r_retry_cnt <= 4'd0;
            end
        end
    end

    assign retry_cnt = r_retry_cnt;
`else
    assign retry_cnt = 4'd0;
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_reset_sequencer
// Brief   : Scoreboard bench for pll_reset_sequencer; expectations are queued
//           with the edge at which each output pattern is due.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       clr_status = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int         at_edge;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W              (6)
    ) u_dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .clr_status(clr_status),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #10 refclk = ~refclk;

    // {pll_rst, sys_rst, ready, lock_lost, retry_cnt}
    function automatic logic [7:0] outs();
        return {pll_rst, sys_rst, ready, lock_lost, retry_cnt};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int n, input logic [7:0] v, input string tag);
        exp_t e;
        e.at_edge = n;
        e.exp     = v;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    // Returns at the falling edge preceding edge n, so values set now are sampled at n.
    task automatic drive_at(input int n);
        @(negedge refclk);
        while (cyc < n - 1) @(negedge refclk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge refclk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].at_edge == cyc) begin
                e = sb.pop_front();
                chk(e.tag, outs(), e.exp);
            end
        end
    end

    initial begin
        int t;
        int base;
        logic [3:0] r_exp;

        for (int i = 0; i < 3; i++) begin
            @(negedge refclk);
            chk("rst_val", outs(), 8'hC0);
        end
        rst = 1'b0;
        push(4, 8'hC0, "pll_rst_e1");
        push(6, 8'hC0, "pll_rst_e3");
        push(7, 8'h40, "pll_rst_off");

        // Clean lock sampled at edge 13: release due 14 edges later.
        drive_at(13);
        pll_locked = 1'b1;
        push(26, 8'h40, "lock_pre_rel");
        push(27, 8'h20, "lock_release");

        drive_at(32);
        pll_locked = 1'b0;
        push(33, 8'h20, "loss_k1");
        push(34, 8'hD0, "loss_k2");
        push(37, 8'hD0, "loss_prst_4");
        push(38, 8'h50, "loss_prst_off");
        drive_at(40);
        clr_status = 1'b1;
        push(40, 8'h40, "clr_lost");
        drive_at(41);
        clr_status = 1'b0;

        // Chatter: high 5 samples, low 1, then high from edge 48.
        drive_at(42);
        pll_locked = 1'b1;
        push(56, 8'h40, "chatter_noearly");
        push(61, 8'h40, "chatter_pre_rel");
        push(62, 8'h20, "chatter_release");
        drive_at(47);
        pll_locked = 1'b0;
        drive_at(48);
        pll_locked = 1'b1;

        t = 66;
        drive_at(t);
        pll_locked = 1'b0;
        push(t + 2, 8'hD0, "to_loss");
        push(t + 6, 8'h50, "to_wait");
        for (int n = 1; n <= 17; n++) begin
            base = t + 2 + 36 * n;
`ifdef PLL_LOCK_TIMEOUT_EN
            r_exp = (n > 15) ? 4'd15 : 4'(n);
            push(base,     8'hD0 | {4'h0, r_exp}, "to_retry");
            push(base + 3, 8'hD0 | {4'h0, r_exp}, "to_prst_hold");
            push(base + 4, 8'h50 | {4'h0, r_exp}, "to_prst_off");
`else
            r_exp = 4'd0;
            push(base,     8'h50 | {4'h0, r_exp}, "nto_wait");
            push(base + 3, 8'h50 | {4'h0, r_exp}, "nto_wait3");
            push(base + 4, 8'h50 | {4'h0, r_exp}, "nto_wait4");
`endif
        end

        drive_at(690);
        clr_status = 1'b1;
        push(690, 8'h40, "clr_status_all");
        drive_at(691);
        clr_status = 1'b0;
        pll_locked = 1'b1;
        push(705, 8'h20, "relock_release");

        for (int i = 0; i < 40 && (sb.size() > 0 || cyc < 706); i++) @(negedge refclk);
        chk("sb_drain", 8'(sb.size()), 8'd0);

        // Asynchronous reset mid-cycle, well away from any rising edge.
        @(negedge refclk);
        #3 rst = 1'b1;
        #2 chk("async_rst", outs(), 8'hC0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
